// File: rtl/tts_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tts_pkg
// Description : Shared types and constants for the truth-table sweeper.
//               Holds the sweep FSM state encoding, the vector count and
//               index width, and the index-bit to stimulus-pin mapping.
// Revision    : 1.0 - initial release
// ============================================================================
package tts_pkg;

    localparam int VEC_N = 16;
    localparam int IDX_W = 4;

    // Which bit of the vector index drives each stimulus pin.
    localparam int c_x1_bit = 3;
    localparam int c_x2_bit = 2;
    localparam int c_y1_bit = 1;
    localparam int c_y2_bit = 0;

    // State names carry an ST_ prefix so they never collide with the
    // SETTLE timing parameter of the top level.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FINISH = 2'd3
    } tts_state_t;

endpackage : tts_pkg
`default_nettype wire

// File: rtl/tts_settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : tts_settle_timer
// Description : Loadable down-counter that times how long each stimulus
//               vector is held before the function output is sampled.
//               load has priority over dec; the count stops at zero.
// Ports       : clk, rst_n (async, active-low)
//               load  - load value into the counter
//               dec   - decrement by one when non-zero
//               value - load value
//               zero  - count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module tts_settle_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= value;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);

endmodule : tts_settle_timer
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper
// Description : Drives all 16 input vectors of a 4-input, 1-output
//               combinational function and captures its output b into a
//               16-bit truth table, with a start/done handshake.
//               Each vector is held SETTLE+1 cycles; b is sampled after the
//               stimulus has been stable for SETTLE cycles.
// Parameters  : SETTLE - hold cycles before sampling, legal range 1..15
// Ports       : clk, rst_n (async, active-low), start, b
//               x1/x2/y1/y2 - registered stimulus from the vector index
//               busy, done, truth[15:0]
//               expected, mismatch, mismatch_idx - only with TTS_CHECK_EN
// Macro       : TTS_CHECK_EN - adds the on-line compare against 'expected'
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweeper
    import tts_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             b,
    output logic             x1,
    output logic             x2,
    output logic             y1,
    output logic             y2,
    output logic             busy,
    output logic             done,
`ifdef TTS_CHECK_EN
    input  logic [VEC_N-1:0] expected,
    output logic             mismatch,
    output logic [IDX_W-1:0] mismatch_idx,
`endif
    output logic [VEC_N-1:0] truth
);

    localparam logic [IDX_W-1:0] c_settle_load = IDX_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0] c_last_idx    = IDX_W'(VEC_N - 1);

    tts_state_t       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_stim;
    logic             r_busy;
    logic             r_done;
    logic [VEC_N-1:0] r_truth;
`ifdef TTS_CHECK_EN
    logic             r_mismatch;
    logic [IDX_W-1:0] r_mismatch_idx;
`endif

    logic w_load;
    logic w_dec;
    logic w_cnt_zero;

    // The timer is reloaded whenever a new vector begins its settle window.
    always_comb begin
        w_load = 1'b0;
        w_dec  = 1'b0;
        case (r_state)
            ST_IDLE:   w_load = start;
            ST_SETTLE: w_dec  = !w_cnt_zero;
            ST_SAMPLE: w_load = (r_idx != c_last_idx);
            default:   ;
        endcase
    end

    tts_settle_timer #(
        .WIDTH (IDX_W)
    ) u_settle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .dec   (w_dec),
        .value (c_settle_load),
        .zero  (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_idx          <= '0;
            r_stim         <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_truth        <= '0;
`ifdef TTS_CHECK_EN
            r_mismatch     <= 1'b0;
            r_mismatch_idx <= '0;
`endif
        end else begin
            // Stimulus trails idx by one edge, so the function sees each
            // vector for SETTLE full cycles before the SAMPLE edge.
            r_stim <= r_idx;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_idx          <= '0;
                        r_truth        <= '0;
                        r_busy         <= 1'b1;
                        r_state        <= ST_SETTLE;
`ifdef TTS_CHECK_EN
                        r_mismatch     <= 1'b0;
                        r_mismatch_idx <= '0;
`endif
                    end
                end
                ST_SETTLE: begin
                    if (w_cnt_zero) begin
                        r_state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    r_truth[r_idx] <= b;
`ifdef TTS_CHECK_EN
                    // Only the first differing vector is reported.
                    if ((b != expected[r_idx]) && !r_mismatch) begin
                        r_mismatch     <= 1'b1;
                        r_mismatch_idx <= r_idx;
                    end
`endif
                    // Explicit end test; idx never wraps within a sweep.
                    if (r_idx == c_last_idx) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_FINISH;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= ST_SETTLE;
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign x1    = r_stim[c_x1_bit];
    assign x2    = r_stim[c_x2_bit];
    assign y1    = r_stim[c_y1_bit];
    assign y2    = r_stim[c_y2_bit];
    assign busy  = r_busy;
    assign done  = r_done;
    assign truth = r_truth;
`ifdef TTS_CHECK_EN
    assign mismatch     = r_mismatch;
    assign mismatch_idx = r_mismatch_idx;
`endif

endmodule : truth_table_sweeper
`default_nettype wire
